// File: rtl/adder_measure_sequencer.sv
// adder_measure_sequencer
// Runs a sweep of measurements on the instrumented adder ring-oscillator
// core: for each run it pulses the core counter reset, loads the
// integration time, enables the counter until the core reports done, waits
// a settle time and captures the ring-oscillator count. Min, max and sum of
// the captured counts are reported at the end of the sweep.
//
// Ports
//   clk, reset_n             : clock, synchronous active-low reset
//   start, abort             : sweep control (start sampled in IDLE only)
//   num_runs                 : runs per sweep (0 ignores start)
//   integration_time         : passed to the core, also bounds the watchdog
//   core_done, core_count    : status from the core
//   core_reset, core_counter_load, core_counter_enable,
//   core_integration_time    : controls to the core (all registered)
//   busy, result_valid, timeout_err, runs_done,
//   count_min, count_max, count_sum : sweep status and statistics
//
// Handshake: start is a level sampled each cycle in IDLE; a sweep is
// accepted when start=1 and num_runs!=0. result_valid is a one-cycle pulse
// with no back-pressure; results stay stable until the next accepted start.
module adder_measure_sequencer #(
  parameter int RUN_W         = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT_W     = 34
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [RUN_W-1:0]     num_runs,
  input  logic [31:0]          integration_time,
  input  logic                 core_done,
  input  logic [31:0]          core_count,
  output logic                 core_reset,
  output logic                 core_counter_load,
  output logic                 core_counter_enable,
  output logic [31:0]          core_integration_time,
  output logic                 busy,
  output logic                 result_valid,
  output logic                 timeout_err,
  output logic [RUN_W-1:0]     runs_done,
  output logic [31:0]          count_min,
  output logic [31:0]          count_max,
  output logic [32+RUN_W-1:0]  count_sum
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_LOAD    = 3'd2,
    S_RUN     = 3'd3,
    S_SETTLE  = 3'd4,
    S_CAPTURE = 3'd5,
    S_FINISH  = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [RUN_W-1:0]     r_num_runs;
  logic [31:0]          r_int_time;
  logic [RUN_W-1:0]     r_runs_done;
  logic [31:0]          r_count_min;
  logic [31:0]          r_count_max;
  logic [32+RUN_W-1:0]  r_count_sum;
  logic                 r_timeout_err;
  logic [TIMEOUT_W-1:0] r_wd;
  logic [SET_W-1:0]     r_settle_cnt;

  logic                 r_core_reset;
  logic                 r_core_load;
  logic                 r_core_enable;
  logic                 r_busy;
  logic                 r_result_valid;

  logic                 w_accept;
  logic                 w_first_run;
  logic [TIMEOUT_W-1:0] w_wd_next;
  logic [TIMEOUT_W-1:0] w_wd_limit;
  logic                 w_timeout;
  logic                 w_done_seen;
  logic                 w_settle_last;
  logic [RUN_W-1:0]     w_runs_inc;
  logic                 w_capture;
  logic                 w_timeout_set;

  logic                 w_core_reset_d;
  logic                 w_core_load_d;
  logic                 w_core_enable_d;
  logic                 w_busy_d;
  logic                 w_result_valid_d;

  assign w_accept    = (r_state == S_IDLE) && start && (num_runs != '0);
  // w_wd_next is the 1-based index of the current RUN cycle.
  assign w_wd_next   = r_wd + TIMEOUT_W'(1);
  assign w_first_run = (r_wd == '0);
  assign w_wd_limit  = TIMEOUT_W'(r_int_time) + TIMEOUT_W'(16);
  assign w_timeout   = (w_wd_next > w_wd_limit);
  // done may still be high from the previous run in the first RUN cycle.
  assign w_done_seen = core_done && !w_first_run;
  assign w_settle_last = (r_settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign w_runs_inc  = r_runs_done + RUN_W'(1);
  assign w_capture   = (r_state == S_CAPTURE) && !abort;
  // A late done wins over the watchdog in the same cycle.
  assign w_timeout_set = (r_state == S_RUN) && !abort && !w_done_seen && w_timeout;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; abort overrides every non-IDLE transition.
  always_comb begin
    w_next_state = r_state;
    if (r_state == S_IDLE) begin
      if (w_accept) w_next_state = S_RESET;
    end else if (abort) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_RESET:   w_next_state = S_LOAD;
        S_LOAD:    w_next_state = S_RUN;
        S_RUN: begin
          if (w_done_seen)    w_next_state = S_SETTLE;
          else if (w_timeout) w_next_state = S_IDLE;
        end
        S_SETTLE:  if (w_settle_last) w_next_state = S_CAPTURE;
        S_CAPTURE: w_next_state = (w_runs_inc == r_num_runs) ? S_FINISH : S_RESET;
        S_FINISH:  w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  // Output logic: decoded from the next state so the registered outputs
  // line up with the state they belong to.
  always_comb begin
    w_core_reset_d   = (w_next_state == S_RESET);
    w_core_load_d    = (w_next_state == S_LOAD);
    w_core_enable_d  = (w_next_state == S_RUN);
    w_busy_d         = (w_next_state != S_IDLE) && (w_next_state != S_FINISH);
    w_result_valid_d = (w_next_state == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_core_reset   <= 1'b1;
      r_core_load    <= 1'b0;
      r_core_enable  <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
    end else begin
      r_core_reset   <= w_core_reset_d;
      r_core_load    <= w_core_load_d;
      r_core_enable  <= w_core_enable_d;
      r_busy         <= w_busy_d;
      r_result_valid <= w_result_valid_d;
    end
  end

  // Watchdog and settle counters; both restart whenever their state is left.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wd         <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_wd         <= (r_state == S_RUN) ? w_wd_next : '0;
      r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + SET_W'(1) : '0;
    end
  end

  // Sweep parameters and statistics
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_num_runs    <= '0;
      r_int_time    <= '0;
      r_runs_done   <= '0;
      r_count_min   <= '1;
      r_count_max   <= '0;
      r_count_sum   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_num_runs    <= num_runs;
        r_int_time    <= integration_time;
        r_runs_done   <= '0;
        r_count_min   <= '1;
        r_count_max   <= '0;
        r_count_sum   <= '0;
        r_timeout_err <= 1'b0;
      end else if (w_capture) begin
        r_runs_done <= w_runs_inc;
        r_count_sum <= r_count_sum + {{RUN_W{1'b0}}, core_count};
        if (core_count < r_count_min) r_count_min <= core_count;
        if (core_count > r_count_max) r_count_max <= core_count;
      end
      if (w_timeout_set) r_timeout_err <= 1'b1;
    end
  end

  assign core_reset            = r_core_reset;
  assign core_counter_load     = r_core_load;
  assign core_counter_enable   = r_core_enable;
  assign core_integration_time = r_int_time;
  assign busy                  = r_busy;
  assign result_valid          = r_result_valid;
  assign timeout_err           = r_timeout_err;
  assign runs_done             = r_runs_done;
  assign count_min             = r_count_min;
  assign count_max             = r_count_max;
  assign count_sum             = r_count_sum;

endmodule

// File: tb/tb_adder_measure_sequencer.sv
module tb_adder_measure_sequencer;

  localparam int RUN_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [RUN_W-1:0]  num_runs = '0;
  logic [31:0]       integration_time = '0;
  logic              core_done;
  logic [31:0]       core_count = '0;
  logic              core_reset;
  logic              core_counter_load;
  logic              core_counter_enable;
  logic [31:0]       core_integration_time;
  logic              busy;
  logic              result_valid;
  logic              timeout_err;
  logic [RUN_W-1:0]  runs_done;
  logic [31:0]       count_min;
  logic [31:0]       count_max;
  logic [39:0]       count_sum;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  adder_measure_sequencer #(
    .RUN_W(RUN_W), .SETTLE_CYCLES(2), .TIMEOUT_W(34)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .num_runs(num_runs), .integration_time(integration_time),
    .core_done(core_done), .core_count(core_count),
    .core_reset(core_reset), .core_counter_load(core_counter_load),
    .core_counter_enable(core_counter_enable),
    .core_integration_time(core_integration_time),
    .busy(busy), .result_valid(result_valid), .timeout_err(timeout_err),
    .runs_done(runs_done), .count_min(count_min), .count_max(count_max),
    .count_sum(count_sum)
  );

  // ---------------- core model ----------------
  // Integration counter loaded on counter_load, decremented while enabled;
  // done when it reaches zero after a load. Each load presents the next
  // count value from cnt_q as the ring-oscillator result.
  logic [31:0] cnt_q[$];
  logic [31:0] m_cnt = '0;
  logic        m_loaded = 1'b0;
  logic        force_done = 1'b0;
  logic        suppress_done = 1'b0;

  always @(posedge clk) begin
    if (core_reset) begin
      m_cnt    <= '0;
      m_loaded <= 1'b0;
    end else if (core_counter_load) begin
      m_cnt    <= core_integration_time;
      m_loaded <= 1'b1;
      core_count <= (cnt_q.size() > 0) ? cnt_q.pop_front() : 32'd0;
    end else if (core_counter_enable && m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end
  end

  assign core_done = force_done | (m_loaded && (m_cnt == 0) && !suppress_done);

  // ---------------- scoreboard ----------------
  // {runs_done, count_sum, count_max, count_min}
  logic [111:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (result_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got result_valid=1 expected no result");
      end else begin
        logic [111:0] e;
        logic [111:0] g;
        e = exp_q.pop_front();
        g = {runs_done, count_sum, count_max, count_min};
        if (g !== e) begin
          n_fail++;
          $display("FAIL result_stats: got runs=%0d sum=%0h max=%0h min=%0h expected runs=%0d sum=%0h max=%0h min=%0h",
                   g[111:104], g[103:64], g[63:32], g[31:0],
                   e[111:104], e[103:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0]       n;
    logic [31:0]      it;
    logic             fd;
    logic [3:0][31:0] c;
    logic [31:0]      emin;
    logic [31:0]      emax;
    logic [39:0]      esum;
    logic [15:0]      ecyc;
  } vec_t;

  vec_t vecs[5];

  task automatic set_vec(input int idx, input logic [7:0] n, input logic [31:0] it,
                         input logic fd, input logic [31:0] c0, input logic [31:0] c1,
                         input logic [31:0] c2, input logic [31:0] c3,
                         input logic [31:0] emin, input logic [31:0] emax,
                         input logic [39:0] esum, input logic [15:0] ecyc);
    vecs[idx].n = n;       vecs[idx].it = it;     vecs[idx].fd = fd;
    vecs[idx].c[0] = c0;   vecs[idx].c[1] = c1;
    vecs[idx].c[2] = c2;   vecs[idx].c[3] = c3;
    vecs[idx].emin = emin; vecs[idx].emax = emax;
    vecs[idx].esum = esum; vecs[idx].ecyc = ecyc;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_sweep(input vec_t v);
    int rv_cyc;
    int resets;
    cnt_q.delete();
    for (int i = 0; i < int'(v.n); i++) cnt_q.push_back(v.c[i]);
    force_done = v.fd;
    exp_q.push_back({v.n, v.esum, v.emax, v.emin});
    @(negedge clk);
    num_runs = v.n;
    integration_time = v.it;
    start = 1'b1;
    @(posedge clk);
    rv_cyc = -1;
    resets = 0;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        check("sweep_busy_c1", busy, 1);
        check("sweep_timeout_cleared", timeout_err, 0);
      end
      if (c == 2) check("sweep_load_c2", core_counter_load, 1);
      if (core_reset) resets++;
      if (result_valid) begin
        rv_cyc = c;
        break;
      end
    end
    check("rv_latency", 64'(rv_cyc), 64'(v.ecyc));
    check("core_reset_pulses", 64'(resets), 64'(v.n));
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_runs_done", runs_done, v.n);
    check("idle_rv_low", result_valid, 0);
    force_done = 1'b0;
  endtask

  task automatic timeout_seq();
    int saw_rv;
    saw_rv = 0;
    cnt_q.delete();
    suppress_done = 1'b1;
    @(negedge clk);
    num_runs = 8'd2;
    integration_time = 32'd5;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (result_valid) saw_rv = 1;
      if (c == 24) begin
        check("to_busy_last_run_cycle", busy, 1);
        check("to_err_not_yet", timeout_err, 0);
      end
      if (c == 25) begin
        check("to_busy_dropped", busy, 0);
        check("to_err_set", timeout_err, 1);
        check("to_runs_done", runs_done, 0);
      end
      if (c == 40) check("to_err_sticky", timeout_err, 1);
    end
    check("to_no_result", 64'(saw_rv), 0);
    suppress_done = 1'b0;
  endtask

  task automatic abort_seq();
    int saw_rv;
    saw_rv = 0;
    cnt_q.delete();
    cnt_q.push_back(32'd10); cnt_q.push_back(32'd20);
    cnt_q.push_back(32'd30); cnt_q.push_back(32'd40);
    @(negedge clk);
    num_runs = 8'd4;
    integration_time = 32'd3;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (result_valid) saw_rv = 1;
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        start = 1'b1;       // ignored while busy
        num_runs = 8'd1;    // must not affect the latched run count
        integration_time = 32'd0;
      end
      if (c == 6) begin
        start = 1'b0;
        num_runs = 8'd4;
      end
      if (c == 13) abort = 1'b1;
      if (c == 14) begin
        abort = 1'b0;
        check("ab_busy", busy, 0);
        check("ab_runs_done", runs_done, 1);
        check("ab_sum", count_sum, 10);
        check("ab_min", count_min, 10);
        check("ab_max", count_max, 10);
        check("ab_enable", core_counter_enable, 0);
        check("ab_int_time_kept", core_integration_time, 3);
      end
    end
    check("ab_no_result", 64'(saw_rv), 0);
  endtask

  // start+abort together in IDLE is accepted; abort in CAPTURE drops the sample.
  task automatic abort_capture_seq();
    int saw_rv;
    saw_rv = 0;
    cnt_q.delete();
    cnt_q.push_back(32'h77);
    @(negedge clk);
    num_runs = 8'd1;
    integration_time = 32'd2;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (result_valid) saw_rv = 1;
      if (c == 1) begin
        start = 1'b0;
        abort = 1'b0;
        check("sa_start_wins", busy, 1);
      end
      if (c == 8) abort = 1'b1;
      if (c == 9) begin
        abort = 1'b0;
        check("ac_busy", busy, 0);
        check("ac_runs_done", runs_done, 0);
        check("ac_sum", count_sum, 0);
        check("ac_min", count_min, 32'hFFFF_FFFF);
      end
    end
    check("ac_no_result", 64'(saw_rv), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_load"}, core_counter_load, 0);
    check({tag, "_enable"}, core_counter_enable, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rv"}, result_valid, 0);
    check({tag, "_timeout"}, timeout_err, 0);
    check({tag, "_runs_done"}, runs_done, 0);
    check({tag, "_min"}, count_min, 32'hFFFF_FFFF);
    check({tag, "_max"}, count_max, 0);
    check({tag, "_sum"}, count_sum, 0);
    check({tag, "_int_time"}, core_integration_time, 0);
  endtask

  task automatic reset_mid_run_seq();
    cnt_q.delete();
    cnt_q.push_back(32'h99); cnt_q.push_back(32'h98);
    @(negedge clk);
    num_runs = 8'd2;
    integration_time = 32'd10;
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 5) begin
        check("rr_in_run", core_counter_enable, 1);
        reset_n = 1'b0;
      end
      if (c == 6) check_reset_values("rr");
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rr_released_core_reset", core_reset, 0);
  endtask

  task automatic zero_runs_seq();
    @(negedge clk);
    num_runs = 8'd0;
    integration_time = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("zr_busy", busy, 0);
    check("zr_core_reset", core_reset, 0);
    @(negedge clk);
    check("zr_busy_later", busy, 0);
  endtask

  // ---------------- main ----------------
  initial begin
    set_vec(0, 8'd1, 32'd10, 1'b0, 32'h1234, 0, 0, 0,
            32'h1234, 32'h1234, 40'h1234, 16'd17);
    set_vec(1, 8'd3, 32'd4, 1'b0, 32'd100, 32'd50, 32'd200, 0,
            32'd50, 32'd200, 40'd350, 16'd31);
    set_vec(2, 8'd2, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'd0, 0, 0,
            32'd0, 32'hFFFF_FFFF, 40'h00_FFFF_FFFF, 16'd17);
    set_vec(3, 8'd4, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 40'h03_FFFF_FFFC, 16'd29);
    // done held high entering RUN: first RUN cycle ignored, SETTLE from cycle 5
    set_vec(4, 8'd1, 32'd10, 1'b1, 32'h55, 0, 0, 0,
            32'h55, 32'h55, 40'h55, 16'd8);

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset_n = 1'b1;
    @(negedge clk);

    timeout_seq();
    for (int i = 0; i < 5; i++) run_sweep(vecs[i]);
    abort_capture_seq();
    abort_seq();
    // results from a completed sweep hold in IDLE until the next start
    run_sweep(vecs[1]);
    repeat (5) @(negedge clk);
    check("hold_min", count_min, 32'd50);
    check("hold_sum", count_sum, 40'd350);
    reset_mid_run_seq();
    zero_runs_seq();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
